// File: rtl/serial_sub_pkg.sv
// Shared definitions for the nibble-serial word subtractor.
// Holds the nibble width, the control state encoding and the WORDW legality check.
package serial_sub_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // True when w is a whole, non-zero number of nibbles.
   function automatic bit wordw_is_valid(input int w);
      return (w >= NIBBLE_W) && ((w % NIBBLE_W) == 0);
   endfunction

endpackage

// File: rtl/fourbitsub.sv
// Four-bit ripple-borrow subtractor: diff = a - b - bin, bout = borrow out of bit 3.
// Purely combinational; the serial controller registers its results.
module fourbitsub (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bin,
   output logic [3:0] diff,
   output logic       bout
);

   logic [4:0] borrow;

   assign borrow[0] = bin;

   for (genvar gi = 0; gi < 4; gi++) begin : g_bit
      logic a_xor_b;
      assign a_xor_b        = a[gi] ^ b[gi];
      assign diff[gi]       = a_xor_b ^ borrow[gi];
      // Borrow when a < b, or when equal and a borrow is already pending.
      assign borrow[gi + 1] = (~a[gi] & b[gi]) | (~a_xor_b & borrow[gi]);
   end

   assign bout = borrow[4];

endmodule

// File: rtl/serial_word_sub.sv
// Multi-cycle word subtractor: A - B - bin, one nibble per clock, LS nibble first.
// Optional build macro SERIAL_SUB_SAT_EN saturates diff at zero when the final borrow is set.
module serial_word_sub
   import serial_sub_pkg::*;
#(
   parameter int WORDW = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WORDW-1:0] a,
   input  logic [WORDW-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WORDW-1:0] diff,
   output logic             bout
);

   localparam int N  = WORDW / NIBBLE_W;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

`ifdef SERIAL_SUB_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   if (!wordw_is_valid(WORDW)) begin : g_bad_wordw
      $error("serial_word_sub: WORDW must be a non-zero multiple of NIBBLE_W");
   end

   state_t              state_reg;
   logic [KW-1:0]       k_reg;
   logic [WORDW-1:0]    a_reg;
   logic [WORDW-1:0]    b_reg;
   logic                borrow_reg;
   logic [WORDW-1:0]    diff_reg;
   logic                bout_reg;

   logic [NIBBLE_W-1:0] a_nib_arr [N];
   logic [NIBBLE_W-1:0] b_nib_arr [N];
   logic [NIBBLE_W-1:0] a_nib;
   logic [NIBBLE_W-1:0] b_nib;
   logic [NIBBLE_W-1:0] nib_diff;
   logic                nib_bout;
   logic [WORDW-1:0]    diff_next;
   logic                last_step;

   // Nibble views of the latched operands and the merged result word.
   for (genvar gi = 0; gi < N; gi++) begin : g_nib
      assign a_nib_arr[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
      assign b_nib_arr[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
      assign diff_next[gi*NIBBLE_W +: NIBBLE_W] =
         (k_reg == KW'(gi)) ? nib_diff : diff_reg[gi*NIBBLE_W +: NIBBLE_W];
   end

   assign a_nib     = a_nib_arr[k_reg];
   assign b_nib     = b_nib_arr[k_reg];
   assign last_step = (k_reg == K_LAST);

   fourbitsub u_nibble (
      .a    (a_nib),
      .b    (b_nib),
      .bin  (borrow_reg),
      .diff (nib_diff),
      .bout (nib_bout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         k_reg      <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         borrow_reg <= 1'b0;
         diff_reg   <= '0;
         bout_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_reg      <= a;
                  b_reg      <= b;
                  borrow_reg <= bin;
                  k_reg      <= '0;
                  state_reg  <= RUN;
               end
            end
            RUN: begin
               borrow_reg <= nib_bout;
               if (last_step) begin
                  // Saturation only applies to the fully assembled word.
                  diff_reg  <= (SAT_EN && nib_bout) ? '0 : diff_next;
                  bout_reg  <= nib_bout;
                  k_reg     <= '0;
                  state_reg <= DONE;
               end else begin
                  diff_reg  <= diff_next;
                  k_reg     <= k_reg + KW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign diff      = diff_reg;
   assign bout      = bout_reg;

endmodule

// File: tb/tb_serial_word_sub.sv
// Directed bench for serial_word_sub: stimulus pushes expected results, a monitor pops at delivery.
// Expected values follow SERIAL_SUB_SAT_EN when the bench is built with it.
module tb_serial_word_sub;

   localparam int WORDW = 16;
   localparam int N     = WORDW / 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WORDW-1:0] a = '0;
   logic [WORDW-1:0] b = '0;
   logic             bin = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WORDW-1:0] diff;
   logic             bout;

   typedef struct packed {
      logic [7:0]       id;
      logic [WORDW-1:0] d;
      logic             bo;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   serial_word_sub #(.WORDW(WORDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // Monitor: a result is delivered on a cycle with out_valid && out_ready.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               $display("txn id=%0d diff=0x%04h bout=%0d (required 0x%04h/%0d)",
                        e.id, diff, bout, e.d, e.bo);
               check("sb_diff", 32'(diff), 32'(e.d));
               check("sb_bout", 32'(bout), 32'(e.bo));
            end
         end
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"},  32'(in_ready),  32'd1);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_diff"},      32'(diff),      32'd0);
      check({tag, "_bout"},      32'(bout),      32'd0);
   endtask

   task automatic wait_idle();
      int w = 0;
      while (!in_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      check("in_ready_wait", 32'(in_ready), 32'd1);
   endtask

   // Called #1 after a rising edge. ed/ebo are the wrapped (non-saturated) answers.
   task automatic run_op(input logic [7:0] id, input logic [WORDW-1:0] a_i,
                         input logic [WORDW-1:0] b_i, input logic bin_i,
                         input logic [WORDW-1:0] ed_i, input logic ebo,
                         input int hold, input bit mess);
      logic [WORDW-1:0] ed;
      int lat;
      ed = ed_i;
`ifdef SERIAL_SUB_SAT_EN
      if (ebo) ed = '0;
`endif
      wait_idle();
      out_ready = (hold == 0);
      a = a_i; b = b_i; bin = bin_i; in_valid = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back('{id: id, d: ed, bo: ebo});
      in_valid = 1'b0;
      check("busy_in_ready", 32'(in_ready), 32'd0);
      if (mess) begin
         a = ~a_i; b = a_i ^ 16'h5A5A; bin = ~bin_i; in_valid = 1'b1;
      end
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      check("latency", 32'(lat), 32'(N));
      for (int i = 0; i < hold; i++) begin
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_diff",      32'(diff),      32'(ed));
         check("hold_in_ready",  32'(in_ready),  32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("after_deliver_in_ready",  32'(in_ready),  32'd1);
      check("after_deliver_out_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      check_reset_values("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check_reset_values("post_reset");

      run_op(8'd1, 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 0, 1'b0);
      run_op(8'd2, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 0, 1'b0);
      run_op(8'd3, 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 0, 1'b0);
      run_op(8'd4, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 0, 1'b0);
      run_op(8'd5, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 0, 1'b0);
      run_op(8'd6, 16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 5, 1'b0);
      run_op(8'd7, 16'h5555, 16'h1111, 1'b0, 16'h4444, 1'b0, 0, 1'b1);
      run_op(8'd8, 16'h00FF, 16'h0F0F, 1'b0, 16'hF1F0, 1'b1, 3, 1'b0);

      // Reset two RUN cycles into an operation; nothing is expected from it.
      wait_idle();
      a = 16'hFFFF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_reset_values("mid_run_reset");
      @(posedge clk); #1;
      check_reset_values("mid_run_reset_held");
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(8'd9, 16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b0, 0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
